// File: rtl/dual_port_bram.sv
// True dual-port block RAM: two independent byte-masked read/write ports on one clock,
// registered read data (1-cycle latency), read-first on cross-port collisions, port A wins write conflicts.
module dual_port_bram #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = 6
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,

  input  logic                                   port_A_access_en_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS/8-1:0] port_A_write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       port_A_access_set_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   port_A_write_entry_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   port_A_read_entry_out,
  output logic                                   port_A_read_valid_out,

  input  logic                                   port_B_access_en_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS/8-1:0] port_B_write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       port_B_access_set_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   port_B_write_entry_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   port_B_read_entry_out,
  output logic                                   port_B_read_valid_out
);

  localparam int BYTE_LEN       = 8;
  localparam int WRITE_MASK_LEN = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN;
  localparam logic [SET_PTR_WIDTH_IN_BITS:0] NUM_SET_W = NUM_SET[SET_PTR_WIDTH_IN_BITS:0];

  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_q [NUM_SET];

  logic                                 a_in_range, b_in_range;
  logic                                 a_rd, b_rd, a_wr, b_wr;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] a_rdata_d, a_rdata_q, b_rdata_d, b_rdata_q;
  logic                                 a_vld_d, a_vld_q, b_vld_d, b_vld_q;

  assign a_in_range = {1'b0, port_A_access_set_addr_in} < NUM_SET_W;
  assign b_in_range = {1'b0, port_B_access_set_addr_in} < NUM_SET_W;
  assign a_rd = port_A_access_en_in && (port_A_write_en_in == '0);
  assign b_rd = port_B_access_en_in && (port_B_write_en_in == '0);
  assign a_wr = port_A_access_en_in && (port_A_write_en_in != '0) && a_in_range;
  assign b_wr = port_B_access_en_in && (port_B_write_en_in != '0) && b_in_range;

  // Reads see mem_q before this edge's writes, giving read-first behaviour across ports.
  always_comb begin
    a_rdata_d = a_rdata_q;
    a_vld_d   = 1'b0;
    b_rdata_d = b_rdata_q;
    b_vld_d   = 1'b0;
    if (a_rd) begin
      a_vld_d   = 1'b1;
      a_rdata_d = a_in_range ? mem_q[port_A_access_set_addr_in] : '0;
    end
    if (b_rd) begin
      b_vld_d   = 1'b1;
      b_rdata_d = b_in_range ? mem_q[port_B_access_set_addr_in] : '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      a_rdata_q <= '0;
      a_vld_q   <= 1'b0;
      b_rdata_q <= '0;
      b_vld_q   <= 1'b0;
    end else begin
      a_rdata_q <= a_rdata_d;
      a_vld_q   <= a_vld_d;
      b_rdata_q <= b_rdata_d;
      b_vld_q   <= b_vld_d;
    end
  end

  // Port B is applied first so port A's byte lanes override on a same-address collision.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      if (b_wr)
        for (int i = 0; i < WRITE_MASK_LEN; i++)
          if (port_B_write_en_in[i])
            mem_q[port_B_access_set_addr_in][BYTE_LEN*i +: BYTE_LEN] <=
              port_B_write_entry_in[BYTE_LEN*i +: BYTE_LEN];
      if (a_wr)
        for (int i = 0; i < WRITE_MASK_LEN; i++)
          if (port_A_write_en_in[i])
            mem_q[port_A_access_set_addr_in][BYTE_LEN*i +: BYTE_LEN] <=
              port_A_write_entry_in[BYTE_LEN*i +: BYTE_LEN];
    end
  end

  assign port_A_read_entry_out = a_rdata_q;
  assign port_A_read_valid_out = a_vld_q;
  assign port_B_read_entry_out = b_rdata_q;
  assign port_B_read_valid_out = b_vld_q;

endmodule

// File: tb/tb_dual_port_bram.sv
// Scoreboard bench for dual_port_bram: a reference memory model pushes per-cycle expected
// outputs for each port; a negedge monitor pops and compares against the DUT.
module tb_dual_port_bram;

  localparam int W  = 64;
  localparam int NS = 64;
  localparam int AW = 6;
  localparam int ML = W / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_en, b_en;
  logic [ML-1:0] a_we, b_we;
  logic [AW-1:0] a_ad, b_ad;
  logic [W-1:0]  a_wd, b_wd;
  logic [W-1:0]  a_rd, b_rd;
  logic          a_vl, b_vl;

  always #5 clk = ~clk;

  dual_port_bram #(.SINGLE_ENTRY_SIZE_IN_BITS(W), .NUM_SET(NS), .SET_PTR_WIDTH_IN_BITS(AW)) dut (
    .clk_in(clk), .reset_in(rst_n),
    .port_A_access_en_in(a_en), .port_A_write_en_in(a_we), .port_A_access_set_addr_in(a_ad),
    .port_A_write_entry_in(a_wd), .port_A_read_entry_out(a_rd), .port_A_read_valid_out(a_vl),
    .port_B_access_en_in(b_en), .port_B_write_en_in(b_we), .port_B_access_set_addr_in(b_ad),
    .port_B_write_entry_in(b_wd), .port_B_read_entry_out(b_rd), .port_B_read_valid_out(b_vl)
  );

  typedef struct packed { logic v; logic [W-1:0] d; } exp_t;
  exp_t qa[$], qb[$];

  logic [W-1:0] ref_mem [NS];
  logic [W-1:0] last_a = '0, last_b = '0;
  int total = 0, bad = 0;

  // Drive one cycle of stimulus, then advance the reference model on the same edge.
  task automatic cyc(input logic r,
                     input logic ae, input logic [ML-1:0] awe, input logic [AW-1:0] aad, input logic [W-1:0] awd,
                     input logic be, input logic [ML-1:0] bwe, input logic [AW-1:0] bad_, input logic [W-1:0] bwd);
    logic va, vb;
    rst_n = r; a_en = ae; a_we = awe; a_ad = aad; a_wd = awd;
    b_en = be; b_we = bwe; b_ad = bad_; b_wd = bwd;
    @(posedge clk);
    va = 1'b0; vb = 1'b0;
    if (!r) begin
      last_a = '0; last_b = '0;
    end else begin
      if (ae && awe == '0) begin va = 1'b1; last_a = (int'(aad) < NS) ? ref_mem[aad] : '0; end
      if (be && bwe == '0) begin vb = 1'b1; last_b = (int'(bad_) < NS) ? ref_mem[bad_] : '0; end
      if (be && int'(bad_) < NS)
        for (int i = 0; i < ML; i++) if (bwe[i]) ref_mem[bad_][8*i +: 8] = bwd[8*i +: 8];
      if (ae && int'(aad) < NS)
        for (int i = 0; i < ML; i++) if (awe[i]) ref_mem[aad][8*i +: 8] = awd[8*i +: 8];
    end
    qa.push_back('{va, last_a});
    qb.push_back('{vb, last_b});
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      total += 2;
      if (a_vl !== e.v) begin bad++; $display("FAIL A_valid got=%0b exp=%0b t=%0t", a_vl, e.v, $time); end
      if (a_rd !== e.d) begin bad++; $display("FAIL A_data got=%h exp=%h t=%0t", a_rd, e.d, $time); end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      total += 2;
      if (b_vl !== e.v) begin bad++; $display("FAIL B_valid got=%0b exp=%0b t=%0t", b_vl, e.v, $time); end
      if (b_rd !== e.d) begin bad++; $display("FAIL B_data got=%h exp=%h t=%0t", b_rd, e.d, $time); end
    end
  end

  initial begin
    logic [ML-1:0] m;
    rst_n = 1'b0; a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
    a_ad = '0; b_ad = '0; a_wd = '0; b_wd = '0;
    #2;
    // Reset, with accesses presented that must be ignored.
    cyc(1'b0, 1'b1, 8'hFF, 6'd0, 64'hDEAD, 1'b1, 8'h00, 6'd1, '0);
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

    // Fill the array so every later read has a known value.
    for (int i = 0; i < NS; i += 2)
      cyc(1'b1, 1'b1, 8'hFF, AW'(i), {$urandom, $urandom}, 1'b1, 8'hFF, AW'(i + 1), {$urandom, $urandom});

    // 1-2: write A, read back, continued reads, then idle holds data.
    cyc(1'b1, 1'b1, 8'hFF, 6'd63, 64'hFFFFFFFF_00000000, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b1, 8'h00, 6'd63, '0, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b1, 8'h00, 6'd63, '0, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b1, 8'h00, 6'd63, '0, 1'b0, '0, '0, '0);
    idle(); idle();
    // 3: write/read on B.
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b1, 8'hFF, 6'd63, 64'h00000000_FFFFFFFF);
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b1, 8'h00, 6'd63, '0);
    // 4: A writes addr 4 while B reads addr 63, then A reads addr 4.
    cyc(1'b1, 1'b1, 8'hFF, 6'd4, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 8'h00, 6'd63, '0);
    cyc(1'b1, 1'b1, 8'h00, 6'd4, '0, 1'b0, '0, '0, '0);
    // 5: partial write on A collides with read on B (read-first).
    cyc(1'b1, 1'b1, 8'hFF, 6'd5, 64'h11111111_11111111, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b1, 8'h01, 6'd5, 64'hAAAAAAAA_AAAAAAAA, 1'b1, 8'h00, 6'd5, '0);
    cyc(1'b1, 1'b1, 8'h00, 6'd5, '0, 1'b1, 8'h00, 6'd5, '0);
    // 6: both ports write addr 7; A wins. Then reset mid-read; contents retained.
    cyc(1'b1, 1'b1, 8'hFF, 6'd7, 64'hAAAAAAAA_AAAAAAAA, 1'b1, 8'hFF, 6'd7, 64'hBBBBBBBB_BBBBBBBB);
    cyc(1'b1, 1'b1, 8'h00, 6'd7, '0, 1'b1, 8'h00, 6'd7, '0);
    cyc(1'b0, 1'b1, 8'h00, 6'd7, '0, 1'b1, 8'h00, 6'd7, '0);
    cyc(1'b1, 1'b1, 8'h00, 6'd7, '0, 1'b0, '0, '0, '0);
    // Overlapping partial masks on the same address.
    cyc(1'b1, 1'b1, 8'h0F, 6'd9, 64'h01234567_89ABCDEF, 1'b1, 8'h3C, 6'd9, 64'hFEDCBA98_76543210);
    cyc(1'b1, 1'b1, 8'h00, 6'd9, '0, 1'b1, 8'h00, 6'd9, '0);

    // Randomized traffic, biased toward a few addresses to force collisions.
    for (int n = 0; n < 600; n++) begin
      logic r, ae, be;
      logic [ML-1:0] awe, bwe;
      logic [AW-1:0] aad, bad_;
      r  = ($urandom_range(0, 40) != 0);
      ae = ($urandom_range(0, 3) != 0);
      be = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1:    awe = '0;
        2:       awe = 8'hFF;
        default: awe = ML'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1:    bwe = '0;
        2:       bwe = 8'hFF;
        default: bwe = ML'($urandom);
      endcase
      m = '0;
      aad = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      bad_ = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      cyc(r, ae, awe | m, aad, {$urandom, $urandom}, be, bwe, bad_, {$urandom, $urandom});
    end

    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
